// File: rtl/edge_arb_pkg.sv
// Shared types and sizing helpers for the edge event arbiter.
package edge_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int TS_W = 16;

    // Channel index width; a 2-channel build still needs one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_arb_if.sv
// Event-offer bundle: raw event inputs, offer handshake and status flags.
interface edge_arb_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = edge_arb_pkg::ch_w(NUM_CH);

    logic [NUM_CH-1:0]           i_sig;
    logic                        o_valid;
    logic                        i_ready;
    logic [CH_W-1:0]             o_ch;
    logic [edge_arb_pkg::TS_W-1:0] o_ts;
    logic [NUM_CH-1:0]           o_pending;
    logic [NUM_CH-1:0]           o_ovf;
    logic                        i_clr_ovf;

    modport master (
        input  i_sig, i_ready, i_clr_ovf,
        output o_valid, o_ch, o_ts, o_pending, o_ovf
    );

    modport slave (
        output i_sig, i_ready, i_clr_ovf,
        input  o_valid, o_ch, o_ts, o_pending, o_ovf
    );
endinterface

// File: rtl/edge_detect.sv
// Single-bit edge detector on an already-synchronized input.
module edge_detect #(
    parameter string EDGE_TYPE = "rising"
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_edge
);
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= i_d;
    end

    generate
        if (EDGE_TYPE == "falling") begin : g_fall
            assign o_edge = r_prev & ~i_d;
        end else if (EDGE_TYPE == "both") begin : g_both
            assign o_edge = r_prev ^ i_d;
        end else begin : g_rise
            assign o_edge = i_d & ~r_prev;
        end
    endgenerate
endmodule

// File: rtl/edge_event_arbiter.sv
// Synchronizes per-channel event inputs, latches pending events and offers
// them round-robin over a valid/ready handshake. EDGE_ARB_TIMESTAMP_EN adds timestamps.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int    NUM_CH    = 4,
    parameter string EDGE_TYPE = "rising"
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_sig,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [ch_w(NUM_CH)-1:0]   o_ch,
    output logic [TS_W-1:0]           o_ts,
    output logic [NUM_CH-1:0]         o_pending,
    output logic [NUM_CH-1:0]         o_ovf,
    input  logic                      i_clr_ovf
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0] r_sync1, r_sync2, w_edge, w_acc, w_ovf_set;
    logic [NUM_CH-1:0] r_pending, r_ovf;
    logic [CH_W-1:0]   r_ch, r_last, w_sel;
    state_t            r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            edge_detect #(.EDGE_TYPE(EDGE_TYPE)) u_edge (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_d    (r_sync2[k]),
                .o_edge (w_edge[k])
            );
        end
    endgenerate

    assign o_valid = (r_state == OFFER);

    always_comb begin
        w_acc = '0;
        if (o_valid && i_ready) w_acc[r_ch] = 1'b1;
    end

    // An edge landing on the channel being accepted re-arms it instead of overflowing.
    assign w_ovf_set = w_edge & r_pending & ~w_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_pending <= (r_pending & ~w_acc) | w_edge;
            r_ovf     <= (i_clr_ovf ? '0 : r_ovf) | w_ovf_set;
        end
    end

    always_comb begin
        int  idx;
        logic found;
        w_sel = r_last;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(r_last) + i) % NUM_CH;
            if (!found && r_pending[CH_W'(idx)]) begin
                w_sel = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
        end else begin
            case (r_state)
                IDLE: if (|r_pending) begin
                    r_ch    <= w_sel;
                    r_state <= OFFER;
                end
                OFFER: if (i_ready) begin
                    r_last  <= r_ch;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ch      = r_ch;
    assign o_pending = r_pending;
    assign o_ovf     = r_ovf;

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [NUM_CH-1:0]           w_new;
    logic [TS_W-1:0]             r_cnt, r_ts;
    logic [NUM_CH-1:0][TS_W-1:0] r_ts_ch;

    // A collision re-arm is a fresh event, so it takes a fresh timestamp too.
    assign w_new = w_edge & (~r_pending | w_acc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_ts_ch <= '0;
            r_ts    <= '0;
        end else begin
            r_cnt <= r_cnt + TS_W'(1);
            for (int i = 0; i < NUM_CH; i++)
                if (w_new[i]) r_ts_ch[i] <= r_cnt;
            if (r_state == IDLE && |r_pending) r_ts <= r_ts_ch[w_sel];
            else if (o_valid && i_ready)       r_ts <= '0;
        end
    end

    assign o_ts = r_ts;
`else
    assign o_ts = '0;
`endif
endmodule
